// File: rtl/timebase_tick_gen.sv
// Clock-enable timebase for the DE2 LED-fill / HEX-blink display: divided tick strobes,
// blink level, run/pause/single-step control from debounced push-buttons, 2x speed select.
module timebase_tick_gen #(
    parameter int unsigned FAST_DIV     = 27_777_778,
    parameter int unsigned SLOW_DIV     = 50_000_000,
    parameter int unsigned DEBOUNCE_CYC = 1_000_000
) (
    input  logic CLOCK_50,
    input  logic SW0,
    input  logic KEY_RUN,
    input  logic KEY_STEP,
    input  logic speed_sel,
    output logic tick_fast,
    output logic tick_slow,
    output logic blink,
    output logic running
);

    localparam int unsigned FW = $clog2(FAST_DIV);
    localparam int unsigned SW = $clog2(SLOW_DIV);
    localparam int unsigned DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

    localparam logic [FW-1:0] FAST_TERM_NORM = FW'(FAST_DIV - 1);
    localparam logic [FW-1:0] FAST_TERM_DBL  = FW'(FAST_DIV / 2 - 1);
    localparam logic [SW-1:0] SLOW_TERM_NORM = SW'(SLOW_DIV - 1);
    localparam logic [SW-1:0] SLOW_TERM_DBL  = SW'(SLOW_DIV / 2 - 1);
    localparam logic [DW-1:0] DB_TERM        = DW'(DEBOUNCE_CYC - 1);

    typedef enum logic [1:0] {
        S_RUN,
        S_PAUSE,
        S_STEP
    } state_t;

    // Index 0 = run key, index 1 = step key; all levels active-low.
    logic [1:0]    key_raw;
    logic [1:0]    sync0;
    logic [1:0]    sync1;
    logic [1:0]    db_level;
    logic [1:0]    db_prev;
    logic [DW-1:0] db_cnt [2];
    logic [1:0]    press;
    logic          run_press;
    logic          step_press;

    state_t        state;
    logic [FW-1:0] fast_cnt;
    logic [SW-1:0] slow_cnt;
    logic [FW-1:0] fast_term;
    logic [SW-1:0] slow_term;

    assign key_raw    = {KEY_STEP, KEY_RUN};
    assign press      = db_prev & ~db_level;
    assign run_press  = press[0];
    assign step_press = press[1];

    always_comb begin
        fast_term = speed_sel ? FAST_TERM_DBL : FAST_TERM_NORM;
        slow_term = speed_sel ? SLOW_TERM_DBL : SLOW_TERM_NORM;
    end

    // Counter tracks consecutive synced samples disagreeing with the accepted level;
    // any agreeing sample restarts the qualification window.
    always_ff @(posedge CLOCK_50) begin
        if (SW0) begin
            sync0    <= '1;
            sync1    <= '1;
            db_level <= '1;
            db_prev  <= '1;
            for (int unsigned i = 0; i < 2; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            sync0   <= key_raw;
            sync1   <= sync0;
            db_prev <= db_level;
            for (int unsigned i = 0; i < 2; i++) begin
                if (sync1[i] == db_level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_TERM) begin
                    db_level[i] <= sync1[i];
                    db_cnt[i]   <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + DW'(1);
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (SW0) begin
            state     <= S_RUN;
            fast_cnt  <= '0;
            slow_cnt  <= '0;
            tick_fast <= 1'b0;
            tick_slow <= 1'b0;
            blink     <= 1'b0;
            running   <= 1'b1;
        end else begin
            case (state)
                S_RUN: begin
                    // >= rather than == so a speed change that strands the count
                    // beyond the new terminal wraps on the next edge.
                    if (fast_cnt >= fast_term) begin
                        fast_cnt  <= '0;
                        tick_fast <= 1'b1;
                    end else begin
                        fast_cnt  <= fast_cnt + FW'(1);
                        tick_fast <= 1'b0;
                    end
                    if (slow_cnt >= slow_term) begin
                        slow_cnt  <= '0;
                        tick_slow <= 1'b1;
                        blink     <= ~blink;
                    end else begin
                        slow_cnt  <= slow_cnt + SW'(1);
                        tick_slow <= 1'b0;
                    end
                    if (run_press) begin
                        state   <= S_PAUSE;
                        running <= 1'b0;
                    end
                end
                S_PAUSE: begin
                    tick_fast <= 1'b0;
                    tick_slow <= 1'b0;
                    if (run_press) begin
                        state   <= S_RUN;
                        running <= 1'b1;
                    end else if (step_press) begin
                        state <= S_STEP;
                    end
                end
                S_STEP: begin
                    tick_fast <= 1'b1;
                    tick_slow <= 1'b0;
                    state     <= S_PAUSE;
                end
                default: begin
                    tick_fast <= 1'b0;
                    tick_slow <= 1'b0;
                    state     <= S_PAUSE;
                    running   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timebase_tick_gen.sv
// Randomized and directed checks of timebase_tick_gen against a sample-window reference model.
module tb_timebase_tick_gen;

    localparam int FD = 5;
    localparam int SD = 8;
    localparam int DB = 4;

    logic clk = 1'b0;
    logic sw0 = 1'b1;
    logic key_run = 1'b1;
    logic key_step = 1'b1;
    logic speed_sel = 1'b0;
    logic tick_fast, tick_slow, blink, running;

    int vectors = 0;
    int miscompares = 0;

    timebase_tick_gen #(
        .FAST_DIV    (FD),
        .SLOW_DIV    (SD),
        .DEBOUNCE_CYC(DB)
    ) dut (
        .CLOCK_50 (clk),
        .SW0      (sw0),
        .KEY_RUN  (key_run),
        .KEY_STEP (key_step),
        .speed_sel(speed_sel),
        .tick_fast(tick_fast),
        .tick_slow(tick_slow),
        .blink    (blink),
        .running  (running)
    );

    always #5 clk = ~clk;

    // Reference model: key accepted when the last DB synced samples (input delayed two
    // edges) all oppose the current level; counters as plain modulo arithmetic.
    bit m_hr [DB+1];
    bit m_hs [DB+1];
    bit m_lr = 1, m_ls = 1, m_pr = 0, m_ps = 0;
    int m_mode = 0;   // 0 run, 1 pause, 2 step
    int m_fc = 0, m_sc = 0;
    bit e_tf = 0, e_ts = 0, e_b = 0, e_r = 1;

    logic [3:0] obs, exp_v;
    assign obs   = {tick_fast, tick_slow, blink, running};
    assign exp_v = {e_tf, e_ts, e_b, e_r};

    always @(posedge clk) begin : model
        int ef, es;
        bit all_r, all_s;
        if (sw0) begin
            for (int i = 0; i <= DB; i++) begin
                m_hr[i] = 1;
                m_hs[i] = 1;
            end
            m_lr = 1; m_ls = 1; m_pr = 0; m_ps = 0;
            m_mode = 0; m_fc = 0; m_sc = 0;
            e_tf = 0; e_ts = 0; e_b = 0; e_r = 1;
        end else begin
            ef = speed_sel ? FD / 2 : FD;
            es = speed_sel ? SD / 2 : SD;
            if (m_mode == 0) begin
                e_tf = (m_fc + 1 >= ef);
                m_fc = e_tf ? 0 : m_fc + 1;
                e_ts = (m_sc + 1 >= es);
                m_sc = e_ts ? 0 : m_sc + 1;
                if (e_ts) e_b = !e_b;
                if (m_pr) m_mode = 1;
            end else if (m_mode == 1) begin
                e_tf = 0; e_ts = 0;
                if (m_pr) m_mode = 0;
                else if (m_ps) m_mode = 2;
            end else begin
                e_tf = 1; e_ts = 0; m_mode = 1;
            end
            e_r = (m_mode == 0);
            all_r = 1; all_s = 1;
            for (int i = 1; i <= DB; i++) begin
                if (m_hr[i] == m_lr) all_r = 0;
                if (m_hs[i] == m_ls) all_s = 0;
            end
            m_pr = 0; m_ps = 0;
            if (all_r) begin m_lr = !m_lr; m_pr = !m_lr; end
            if (all_s) begin m_ls = !m_ls; m_ps = !m_ls; end
            for (int i = DB; i > 0; i--) begin
                m_hr[i] = m_hr[i-1];
                m_hs[i] = m_hs[i-1];
            end
            m_hr[0] = key_run;
            m_hs[0] = key_step;
        end
    end

    task automatic test_reset();
        sw0 = 1; key_run = 1; key_step = 1; speed_sel = 0;
        repeat (2) @(negedge clk);
        vectors++;
        if (obs !== 4'b0001) begin
            miscompares++;
            $display("FAIL reset_state got=%b exp=0001", obs);
        end
    endtask

    task automatic test_normal_speed();
        logic [20:0] tf_m = '0, ts_m = '0, bl_m = '0;
        sw0 = 1; speed_sel = 0;
        @(negedge clk);
        sw0 = 0;
        for (int e = 1; e <= 17; e++) begin
            @(negedge clk);
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL normal_model edge=%0d got=%b exp=%b", e, obs, exp_v);
            end
            tf_m[e] = tick_fast; ts_m[e] = tick_slow; bl_m[e] = blink;
        end
        vectors++;
        if (tf_m !== 21'h008420) begin miscompares++; $display("FAIL normal_fast_edges got=%h exp=008420", tf_m); end
        vectors++;
        if (ts_m !== 21'h010100) begin miscompares++; $display("FAIL normal_slow_edges got=%h exp=010100", ts_m); end
        vectors++;
        if (bl_m !== 21'h00ff00) begin miscompares++; $display("FAIL normal_blink got=%h exp=00ff00", bl_m); end
    endtask

    task automatic test_double_speed();
        logic [20:0] tf_m = '0;
        sw0 = 1; speed_sel = 0;
        @(negedge clk);
        sw0 = 0;
        for (int e = 1; e <= 11; e++) begin
            @(negedge clk);
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL double_model edge=%0d got=%b exp=%b", e, obs, exp_v);
            end
            tf_m[e] = tick_fast;
            if (e == 3) speed_sel = 1;
        end
        vectors++;
        if (tf_m !== 21'h000550) begin miscompares++; $display("FAIL double_fast_edges got=%h exp=000550", tf_m); end
        for (int c = 0; c < 80; c++) begin
            if ($urandom_range(0, 5) == 0) speed_sel = ~speed_sel;
            @(negedge clk);
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL speed_toggle_model cyc=%0d got=%b exp=%b", c, obs, exp_v);
            end
        end
        speed_sel = 0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_pause_resume();
        int lat = -1, ticks = 0, held = 0, d = 0;
        bit rose = 0, got = 0;
        key_run = 0;
        for (int j = 1; j <= 10; j++) begin
            @(negedge clk);
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL pause_model cyc=%0d got=%b exp=%b", j, obs, exp_v);
            end
            if (lat < 0 && running === 1'b0) lat = j;
        end
        key_run = 1;
        vectors++;
        if (lat < 0 || lat > 8) begin miscompares++; $display("FAIL pause_latency got=%0d exp<=8", lat); end
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL paused_model cyc=%0d got=%b exp=%b", c, obs, exp_v);
            end
            if (tick_fast || tick_slow) ticks++;
        end
        vectors++;
        if (ticks != 0) begin miscompares++; $display("FAIL paused_ticks got=%0d exp=0", ticks); end
        for (int c = 0; c < 40; c++) begin
            key_run = (c < 10) ? 1'b0 : 1'b1;
            @(negedge clk);
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL resume_model cyc=%0d got=%b exp=%b", c, obs, exp_v);
            end
            if (rose && !got) begin
                d++;
                if (tick_fast) got = 1;
            end
            if (!rose && running) begin rose = 1; held = m_fc; end
        end
        vectors++;
        if (!got || d != FD - held) begin
            miscompares++;
            $display("FAIL resume_distance got=%0d exp=%0d", got ? d : -1, FD - held);
        end
    endtask

    task automatic test_glitch();
        int changes = 0;
        for (int r = 0; r < 12; r++) begin
            int lo, hi;
            lo = $urandom_range(1, DB - 1);
            hi = $urandom_range(1, 4);
            for (int c = 0; c < lo + hi; c++) begin
                key_run = (c < lo) ? 1'b0 : 1'b1;
                @(negedge clk);
                vectors++;
                if (obs !== exp_v) begin
                    miscompares++;
                    $display("FAIL glitch_model rep=%0d got=%b exp=%b", r, obs, exp_v);
                end
                if (running !== 1'b1) changes++;
            end
        end
        key_run = 1;
        vectors++;
        if (changes != 0) begin miscompares++; $display("FAIL glitch_running got=%0d exp=0", changes); end
    endtask

    task automatic test_step();
        int tf_n = 0, ts_n = 0, run_n = 0, pre_tf = 0, d = 0, held;
        bit rose = 0, got = 0;
        for (int c = 0; c < 20; c++) begin
            key_run = (c < 8) ? 1'b0 : 1'b1;
            @(negedge clk);
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL step_pause_model cyc=%0d got=%b exp=%b", c, obs, exp_v);
            end
        end
        vectors++;
        if (running !== 1'b0) begin miscompares++; $display("FAIL step_paused got=%b exp=0", running); end
        held = m_fc;
        for (int c = 0; c < 20; c++) begin
            key_step = (c < 8) ? 1'b0 : 1'b1;
            @(negedge clk);
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL step_model cyc=%0d got=%b exp=%b", c, obs, exp_v);
            end
            tf_n += int'(tick_fast); ts_n += int'(tick_slow); run_n += int'(running);
        end
        vectors++;
        if (tf_n != 1) begin miscompares++; $display("FAIL step_fast_count got=%0d exp=1", tf_n); end
        vectors++;
        if (ts_n != 0 || run_n != 0) begin
            miscompares++;
            $display("FAIL step_side_effects slow=%0d running=%0d exp=0,0", ts_n, run_n);
        end
        for (int c = 0; c < 30; c++) begin
            key_run  = (c < 8) ? 1'b0 : 1'b1;
            key_step = key_run;
            @(negedge clk);
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL both_keys_model cyc=%0d got=%b exp=%b", c, obs, exp_v);
            end
            if (rose && !got) begin
                d++;
                if (tick_fast) got = 1;
            end
            if (!rose && running) rose = 1;
            if (!rose && tick_fast) pre_tf++;
        end
        vectors++;
        if (pre_tf != 0) begin miscompares++; $display("FAIL both_keys_step_dropped got=%0d exp=0", pre_tf); end
        vectors++;
        if (!got || d != FD - held) begin
            miscompares++;
            $display("FAIL step_counts_held got=%0d exp=%0d", got ? d : -1, FD - held);
        end
    endtask

    task automatic test_reset_mid();
        logic [20:0] tf_m = '0;
        sw0 = 1; speed_sel = 0; key_run = 1; key_step = 1;
        @(negedge clk);
        sw0 = 0;
        @(negedge clk);
        key_run = 0;
        for (int c = 0; c < 30; c++) begin
            if (c == 10) key_run = 1;
            @(negedge clk);
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL midreset_model cyc=%0d got=%b exp=%b", c, obs, exp_v);
            end
        end
        sw0 = 1;
        @(negedge clk);
        sw0 = 0;
        vectors++;
        if (obs !== 4'b0001) begin miscompares++; $display("FAIL midreset_state got=%b exp=0001", obs); end
        for (int e = 1; e <= 11; e++) begin
            @(negedge clk);
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL midreset_after edge=%0d got=%b exp=%b", e, obs, exp_v);
            end
            tf_m[e] = tick_fast;
        end
        vectors++;
        if (tf_m !== 21'h000420) begin miscompares++; $display("FAIL midreset_fast_edges got=%h exp=000420", tf_m); end
    endtask

    task automatic test_random();
        int rem_r = 0, rem_s = 0;
        for (int c = 0; c < 3000; c++) begin
            if (rem_r == 0) begin key_run = $urandom_range(0, 1); rem_r = $urandom_range(1, 14); end
            if (rem_s == 0) begin key_step = $urandom_range(0, 1); rem_s = $urandom_range(1, 14); end
            rem_r--; rem_s--;
            if ($urandom_range(0, 24) == 0) speed_sel = ~speed_sel;
            sw0 = ($urandom_range(0, 299) == 0);
            @(negedge clk);
            vectors++;
            if (obs !== exp_v) begin
                miscompares++;
                $display("FAIL random_model cyc=%0d got=%b exp=%b", c, obs, exp_v);
            end
        end
        sw0 = 0; key_run = 1; key_step = 1;
    endtask

    initial begin
        #1ms;
        $display("FAIL timeout simulation did not complete");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_normal_speed();
        test_double_speed();
        test_pause_resume();
        test_glitch();
        test_step();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
